core_mem_requester: RTL and testbench

- Core-side initiator for the shared banked-memory arbiter; one instance per core.
- Turns a single-beat load/store request from the core pipeline into the arbiter's per-core request slice: 2-bit enable, address, write data.
- Waits for the arbiter's ready, captures read data, returns a one-cycle response to the core.
- Hides the arbiter's one-cycle-late ready and its possible duplicate grant from the core.

---
 rtl/core_mem_requester.sv | 140 ++++++++++++++
 tb/tb_core_mem_requester.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_requester.sv
// Core-side requester for the banked-memory arbiter: issues one
// load/store, waits for ready, returns a one-cycle response.
//
// Ports:
//   clk, reset(active-low, async)
//   core side : req_valid/req_we/req_addr/req_wdata -> req_ready,
//               resp_valid/resp_we/resp_rdata
//   arbiter   : enable/addr/wr_data -> ready/rd_data
//   status    : timeout (sticky)
module core_mem_requester #(
  parameter int REG_SIZE  = 8,
  parameter int ADDR_SIZE = 12,
  parameter int TIMEOUT   = 64,
  parameter int CNT_SIZE  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [REG_SIZE-1:0]  req_wdata,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic                 resp_we,
  output logic [REG_SIZE-1:0]  resp_rdata,
  output logic [1:0]           enable,
  output logic [ADDR_SIZE-1:0] addr,
  output logic [REG_SIZE-1:0]  wr_data,
  input  logic                 ready,
  input  logic [REG_SIZE-1:0]  rd_data,
  output logic                 timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    COOL = 2'd2
  } state_t;

  localparam logic [CNT_SIZE-1:0] TO_CNT =
    CNT_SIZE'(TIMEOUT);

  state_t                state_q, state_d;
  logic [1:0]            enable_q, enable_d;
  logic [ADDR_SIZE-1:0]  addr_q, addr_d;
  logic [REG_SIZE-1:0]   wr_data_q, wr_data_d;
  logic                  we_q, we_d;
  logic [CNT_SIZE-1:0]   cnt_q, cnt_d;
  logic                  timeout_q, timeout_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_we_q, resp_we_d;
  logic [REG_SIZE-1:0]   resp_rdata_q, resp_rdata_d;

  always_comb begin
    state_d      = state_q;
    enable_d     = enable_q;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
    resp_valid_d = 1'b0;
    resp_we_d    = resp_we_q;
    resp_rdata_d = resp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          wr_data_d = req_wdata;
          we_d      = req_we;
          enable_d  = req_we ? 2'b10 : 2'b01;
          cnt_d     = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (ready) begin
          enable_d     = 2'b00;
          resp_valid_d = 1'b1;
          resp_we_d    = we_q;
          if (!we_q) resp_rdata_d = rd_data;
          state_d      = COOL;
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (cnt_d >= TO_CNT) timeout_d = 1'b1;
        end
      end
      // Swallows a duplicate ready caused by enable
      // still being high during the completing cycle.
      COOL: begin
        enable_d = 2'b00;
        state_d  = IDLE;
      end
      default: begin
        enable_d = 2'b00;
        state_d  = COOL;
      end
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= COOL;
      enable_q     <= 2'b00;
      addr_q       <= '0;
      wr_data_q    <= '0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      enable_q     <= enable_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_we_q    <= resp_we_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_we    = resp_we_q;
  assign resp_rdata = resp_rdata_q;
  assign enable     = enable_q;
  assign addr       = addr_q;
  assign wr_data    = wr_data_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_core_mem_requester.sv
// Testbench for core_mem_requester: directed vector table,
// hand-written corner sequences, randomized run vs. model.
module tb_core_mem_requester;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [11:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_we;
  logic [7:0]  resp_rdata;
  logic [1:0]  enable;
  logic [11:0] addr;
  logic [7:0]  wr_data;
  logic        ready;
  logic [7:0]  rd_data;
  logic        timeout;

  core_mem_requester #(
    .REG_SIZE(8), .ADDR_SIZE(12),
    .TIMEOUT(TO), .CNT_SIZE(8)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_we(resp_we), .resp_rdata(resp_rdata),
    .enable(enable), .addr(addr), .wr_data(wr_data),
    .ready(ready), .rd_data(rd_data),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_in();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    ready     = 1'b0;
    rd_data   = '0;
  endtask

  typedef struct {
    logic        rv;
    logic        we;
    logic [11:0] a;
    logic        rdy;
    logic [7:0]  rd;
    logic        e_rr;
    logic [1:0]  e_en;
    logic [11:0] e_a;
    logic        e_rv;
    logic [7:0]  e_rd;
  } vec_t;

  function automatic vec_t mk(
      input logic rv, input logic we,
      input logic [11:0] a, input logic rdy,
      input logic [7:0] rd, input logic e_rr,
      input logic [1:0] e_en, input logic [11:0] e_a,
      input logic e_rv, input logic [7:0] e_rd);
    vec_t v;
    v.rv = rv; v.we = we; v.a = a;
    v.rdy = rdy; v.rd = rd;
    v.e_rr = e_rr; v.e_en = e_en; v.e_a = e_a;
    v.e_rv = e_rv; v.e_rd = e_rd;
    return v;
  endfunction

  // behavioural model state (transaction/schedule level)
  bit          m_pend;
  bit          m_we;
  bit [11:0]   m_addr;
  bit [7:0]    m_wd;
  bit [7:0]    m_rd;
  bit          m_rwe;
  bit          m_to;
  int          m_wait;
  int          m_resp;
  int          m_idle;

  initial begin
    vec_t tv[9];
    int   nrv;
    bit   e_rr;

    reset = 1'b0;
    idle_in();
    ready = 1'b1;

    // reset with a stale ready present
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_enable", enable, 2'b00);
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_timeout", timeout, 1'b0);
      chk("rst_addr", addr, 12'h000);
    end
    reset = 1'b1;
    chk("cool_req_ready", req_ready, 1'b0);
    tick();
    chk("post_cool_req_ready", req_ready, 1'b1);
    chk("post_cool_resp_valid", resp_valid, 1'b0);
    ready = 1'b0;

    // load with immediate grant, then duplicate-grant filter
    tv[0] = mk(1, 0, 12'h123, 0, 8'h00,
               1, 2'b00, 12'h000, 0, 8'h00);
    tv[1] = mk(0, 0, 12'h000, 0, 8'h00,
               0, 2'b01, 12'h123, 0, 8'h00);
    tv[2] = mk(0, 0, 12'h000, 1, 8'h5A,
               0, 2'b01, 12'h123, 0, 8'h00);
    tv[3] = mk(0, 0, 12'h000, 0, 8'h00,
               0, 2'b00, 12'h123, 1, 8'h5A);
    tv[4] = mk(1, 0, 12'h045, 0, 8'h00,
               1, 2'b00, 12'h123, 0, 8'h5A);
    tv[5] = mk(0, 0, 12'h000, 1, 8'h11,
               0, 2'b01, 12'h045, 0, 8'h5A);
    tv[6] = mk(0, 0, 12'h000, 1, 8'h22,
               0, 2'b00, 12'h045, 1, 8'h11);
    tv[7] = mk(0, 0, 12'h000, 1, 8'h33,
               1, 2'b00, 12'h045, 0, 8'h11);
    tv[8] = mk(0, 0, 12'h000, 0, 8'h00,
               1, 2'b00, 12'h045, 0, 8'h11);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("v%0d_req_ready", i), req_ready, tv[i].e_rr);
      chk($sformatf("v%0d_enable", i), enable, tv[i].e_en);
      chk($sformatf("v%0d_addr", i), addr, tv[i].e_a);
      chk($sformatf("v%0d_resp_valid", i), resp_valid, tv[i].e_rv);
      chk($sformatf("v%0d_resp_rdata", i), resp_rdata, tv[i].e_rd);
      req_valid = tv[i].rv;
      req_we    = tv[i].we;
      req_addr  = tv[i].a;
      ready     = tv[i].rdy;
      rd_data   = tv[i].rd;
      tick();
    end
    idle_in();

    // store under contention: 5 cycles without ready, hits timeout
    req_valid = 1'b1; req_we = 1'b1;
    req_addr = 12'h801; req_wdata = 8'h3C;
    tick();
    idle_in();
    for (int j = 1; j <= 6; j++) begin
      chk("st_enable", enable, 2'b10);
      chk("st_addr", addr, 12'h801);
      chk("st_wr_data", wr_data, 8'h3C);
      chk("st_req_ready", req_ready, 1'b0);
      chk("st_resp_valid", resp_valid, 1'b0);
      chk($sformatf("st_timeout_w%0d", j), timeout,
          (j - 1 >= TO) ? 1'b1 : 1'b0);
      ready   = (j == 6);
      rd_data = 8'h99;
      tick();
    end
    idle_in();
    nrv = 0;
    chk("st_resp_we", resp_we, 1'b1);
    chk("st_rdata_kept", resp_rdata, 8'h11);
    for (int j = 0; j < 4; j++) begin
      if (resp_valid) nrv++;
      tick();
    end
    chk("st_resp_count", nrv, 1);
    chk("timeout_sticky", timeout, 1'b1);

    // reset while a load is waiting
    chk("mr_req_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_addr = 12'h200;
    tick();
    idle_in();
    chk("mr_enable_pre", enable, 2'b01);
    #2 reset = 1'b0;
    #1;
    chk("mr_enable_async", enable, 2'b00);
    chk("mr_req_ready", req_ready, 1'b0);
    ready = 1'b1; rd_data = 8'hEE;
    for (int j = 0; j < 2; j++) begin
      tick();
      chk("mr_hold_resp_valid", resp_valid, 1'b0);
      chk("mr_timeout_clr", timeout, 1'b0);
    end
    reset = 1'b1;
    chk("mr_cool_req_ready", req_ready, 1'b0);
    tick();
    ready = 1'b0;
    chk("mr_stray_resp_valid", resp_valid, 1'b0);
    chk("mr_idle_req_ready", req_ready, 1'b1);
    chk("mr_rdata_reset", resp_rdata, 8'h00);
    req_valid = 1'b1; req_addr = 12'h3FF;
    tick();
    req_valid = 1'b0; ready = 1'b1; rd_data = 8'hA7;
    tick();
    idle_in();
    chk("mr_next_resp_valid", resp_valid, 1'b1);
    chk("mr_next_resp_we", resp_we, 1'b0);
    chk("mr_next_rdata", resp_rdata, 8'hA7);
    tick();

    // randomized run against the schedule model
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    m_pend = 0; m_we = 0; m_addr = 0; m_wd = 0;
    m_rd = 0; m_rwe = 0; m_to = 0; m_wait = 0;
    m_resp = -1;
    m_idle = cyc + 1;
    for (int n = 0; n < 600; n++) begin
      e_rr = !m_pend && (cyc >= m_idle);
      chk("rnd_req_ready", req_ready, e_rr);
      chk("rnd_enable", enable,
          m_pend ? (m_we ? 2'b10 : 2'b01) : 2'b00);
      chk("rnd_addr", addr, m_addr);
      chk("rnd_wr_data", wr_data, m_wd);
      chk("rnd_resp_valid", resp_valid, cyc == m_resp);
      chk("rnd_resp_we", resp_we, m_rwe);
      chk("rnd_resp_rdata", resp_rdata, m_rd);
      chk("rnd_timeout", timeout, m_to);
      req_valid = ($urandom_range(0, 1) == 1);
      req_we    = $urandom_range(0, 1);
      req_addr  = 12'($urandom);
      req_wdata = 8'($urandom);
      ready     = ($urandom_range(0, 3) == 0);
      rd_data   = 8'($urandom);
      if (m_pend) begin
        if (ready) begin
          m_pend = 0;
          m_resp = cyc + 1;
          m_idle = cyc + 2;
          m_rwe  = m_we;
          if (!m_we) m_rd = rd_data;
        end else begin
          m_wait++;
          if (m_wait >= TO) m_to = 1;
        end
      end else if (e_rr && req_valid) begin
        m_pend = 1;
        m_we   = req_we;
        m_addr = req_addr;
        m_wd   = req_wdata;
        m_wait = 0;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
